// File: rtl/spi_burst_memory_if.sv
// spi_burst_memory_if: SPI pin bundle between a bus master and the spi_burst_memory slave.
interface spi_burst_memory_if;
    logic sclk_pin;
    logic cs_pin;
    logic mosi_pin;
    logic miso_pin;
    logic miso_oe;
    modport master (output sclk_pin, cs_pin, mosi_pin, input miso_pin, miso_oe);
    modport slave (input sclk_pin, cs_pin, mosi_pin, output miso_pin, miso_oe);
endinterface

// File: rtl/spi_burst_memory.sv
// spi_burst_memory: SPI mode-0 slave over a register-file memory; SPI_BURST_EN enables multi-word bursts with address auto-increment.
module spi_burst_memory #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    spi_burst_memory_if.slave        spi,
    output logic                     busy,
    output logic [3:0]               leds
);
    localparam int SW   = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int MAXV = (ADDR_WIDTH > DATA_WIDTH - 1) ? ADDR_WIDTH : DATA_WIDTH - 1;
    localparam int CW   = $clog2(MAXV + 1);
    localparam logic [CW-1:0] CMD_LAST  = CW'(ADDR_WIDTH);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CMD   = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    logic [SYNC_STAGES:0]   sclk_s;
    logic [SYNC_STAGES-1:0] cs_s;
    logic [SYNC_STAGES-1:0] mosi_s;
    logic                   rise, fall, cs_off, mosi;
    logic [1:0]             state;
    logic [CW-1:0]          cnt;
    logic [ADDR_WIDTH-1:0]  addr, addr_inc;
    logic [SW-1:0]          sr;
    logic [DATA_WIDTH-1:0]  tx;
    logic                   miso, oe, wr_pend, wrap, tog, done;
    logic [DATA_WIDTH-1:0]  mem [2**ADDR_WIDTH];

    // sclk carries one extra stage so edges are detected between the last two synchronised samples
    assign rise     = sclk_s[SYNC_STAGES-1] & ~sclk_s[SYNC_STAGES];
    assign fall     = ~sclk_s[SYNC_STAGES-1] & sclk_s[SYNC_STAGES];
    assign cs_off   = cs_s[SYNC_STAGES-1];
    assign mosi     = mosi_s[SYNC_STAGES-1];
    assign addr_inc = addr + ADDR_WIDTH'(1);
    assign busy     = state != IDLE;
    assign leds     = {wrap, tog, state};
    assign spi.miso_pin = miso;
    assign spi.miso_oe  = oe;

    // pin synchronisers; cs resets to deasserted so no transaction starts out of reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_s <= '0;
            cs_s   <= '1;
            mosi_s <= '0;
        end else begin
            sclk_s <= {sclk_s[SYNC_STAGES-1:0], spi.sclk_pin};
            cs_s   <= {cs_s[SYNC_STAGES-2:0], spi.cs_pin};
            mosi_s <= {mosi_s[SYNC_STAGES-2:0], spi.mosi_pin};
        end
    end

    // transaction FSM; a pending write commits even when cs drops in the same clk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            addr    <= '0;
            sr      <= '0;
            tx      <= '0;
            miso    <= 1'b0;
            oe      <= 1'b0;
            wr_pend <= 1'b0;
            wrap    <= 1'b0;
            tog     <= 1'b0;
            done    <= 1'b0;
        end else begin
            wr_pend <= 1'b0;
            if (wr_pend) begin
                tog <= ~tog;
`ifdef SPI_BURST_EN
                addr <= addr_inc;
                if (&addr) wrap <= 1'b1;
`endif
            end
            if (state != IDLE && cs_off) begin
                state <= IDLE;
                oe    <= 1'b0;
                miso  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (!cs_off) begin
                        state <= CMD;
                        cnt   <= '0;
                        wrap  <= 1'b0;
                        done  <= 1'b0;
                    end
                    CMD: if (rise) begin
                        sr <= {sr[SW-2:0], mosi};
                        if (cnt == CMD_LAST) begin
                            cnt  <= '0;
                            addr <= sr[ADDR_WIDTH-1:0];
                            if (mosi) begin
                                state <= READ;
                                tx    <= mem[sr[ADDR_WIDTH-1:0]];
                                oe    <= 1'b1;
                            end else begin
                                state <= WRITE;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    READ: begin
                        if (fall) begin
                            miso <= tx[DATA_WIDTH-1];
                            tx   <= {tx[DATA_WIDTH-2:0], 1'b0};
                        end
                        if (rise) begin
                            if (cnt == DATA_LAST) begin
                                cnt <= '0;
`ifdef SPI_BURST_EN
                                addr <= addr_inc;
                                tx   <= mem[addr_inc];
                                if (&addr) wrap <= 1'b1;
`endif
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
                    default: if (rise && !done) begin
                        sr <= {sr[SW-2:0], mosi};
                        if (cnt == DATA_LAST) begin
                            cnt     <= '0;
                            wr_pend <= 1'b1;
`ifndef SPI_BURST_EN
                            done    <= 1'b1;
`endif
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                endcase
            end
        end
    end

    // synchronous memory write; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_pend) mem[addr] <= sr[DATA_WIDTH-1:0];
    end
endmodule

// File: tb/tb_spi_burst_memory.sv
// tb_spi_burst_memory: directed self-checking bench for spi_burst_memory (SPI_BURST_EN selects burst tests).
module tb_spi_burst_memory;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       busy;
    logic [3:0] leds;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       exp_tog = 1'b0;
    logic [31:0] rd;

    spi_burst_memory_if spi();

    spi_burst_memory #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .spi     (spi.slave),
        .busy    (busy),
        .leds    (leds)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input logic [31:0] dout, input int n, output logic [31:0] din);
        din = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi.mosi_pin = dout[i];
            wait_clk(8);
            spi.sclk_pin = 1'b1;
            din = {din[30:0], spi.miso_pin};
            wait_clk(8);
            spi.sclk_pin = 1'b0;
        end
    endtask

    task automatic cs_begin();
        spi.cs_pin = 1'b0;
        wait_clk(8);
    endtask

    task automatic cs_end();
        wait_clk(8);
        spi.cs_pin = 1'b1;
        wait_clk(16);
    endtask

    task automatic write_word(input logic [6:0] a, input logic [7:0] d);
        logic [31:0] dummy;
        cs_begin();
        xfer({24'd0, a, 1'b0}, 8, dummy);
        xfer({24'd0, d}, 8, dummy);
        cs_end();
        exp_tog = ~exp_tog;
    endtask

    task automatic read_word(input logic [6:0] a, output logic [31:0] d);
        logic [31:0] dummy;
        cs_begin();
        xfer({24'd0, a, 1'b1}, 8, dummy);
        xfer(32'd0, 8, d);
        cs_end();
    endtask

    initial begin
        spi.sclk_pin = 1'b0;
        spi.cs_pin   = 1'b1;
        spi.mosi_pin = 1'b0;
        wait_clk(3);
        check("reset_miso", {31'd0, spi.miso_pin}, 0);
        check("reset_oe", {31'd0, spi.miso_oe}, 0);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_leds", {28'd0, leds}, 0);
        reset_n = 1'b1;
        wait_clk(4);

        // single write then read back
        cs_begin();
        xfer(32'h0A, 8, rd);
        check("wr_state", {30'd0, leds[1:0]}, 3);
        check("wr_busy", {31'd0, busy}, 1);
        xfer(32'hA5, 8, rd);
        cs_end();
        exp_tog = ~exp_tog;
        check("wr_tog", {31'd0, leds[2]}, {31'd0, exp_tog});
        check("wr_idle_busy", {31'd0, busy}, 0);
        cs_begin();
        xfer(32'h0B, 8, rd);
        check("rd_state", {30'd0, leds[1:0]}, 2);
        check("rd_oe", {31'd0, spi.miso_oe}, 1);
        xfer(32'd0, 8, rd);
        check("rd_data", rd, 32'hA5);
        cs_end();
        check("rd_oe_off", {31'd0, spi.miso_oe}, 0);
        check("rd_miso_off", {31'd0, spi.miso_pin}, 0);
        check("rd_tog_same", {31'd0, leds[2]}, {31'd0, exp_tog});

`ifdef SPI_BURST_EN
        // burst write across the top of memory
        cs_begin();
        xfer(32'hFC, 8, rd);
        xfer(32'h11, 8, rd);
        check("bw_wrap0", {31'd0, leds[3]}, 0);
        xfer(32'h22, 8, rd);
        check("bw_wrap1", {31'd0, leds[3]}, 1);
        xfer(32'h33, 8, rd);
        exp_tog = ~exp_tog;
        check("bw_tog", {31'd0, leds[2]}, {31'd0, exp_tog});
        cs_end();
        check("bw_wrap_hold", {31'd0, leds[3]}, 1);
        // burst read 0x7E..0x00
        cs_begin();
        xfer(32'hFD, 8, rd);
        check("br_wrap_clr", {31'd0, leds[3]}, 0);
        xfer(32'd0, 24, rd);
        check("br_data3", rd, 32'h112233);
        cs_end();
        // burst read across the wrap with busy timing
        cs_begin();
        xfer(32'hFF, 8, rd);
        xfer(32'd0, 8, rd);
        check("br_w0", rd, 32'h22);
        check("br_busy0", {31'd0, busy}, 1);
        check("br_wrap_set", {31'd0, leds[3]}, 1);
        xfer(32'd0, 8, rd);
        check("br_w1", rd, 32'h33);
        check("br_busy1", {31'd0, busy}, 1);
        wait_clk(8);
        spi.cs_pin = 1'b1;
        wait_clk(1);
        check("br_busy_cs1", {31'd0, busy}, 1);
        wait_clk(3);
        check("br_busy_cs4", {31'd0, busy}, 0);
        wait_clk(12);
`else
        // single-word mode: second word ignored, no increment
        write_word(7'h06, 8'h66);
        cs_begin();
        xfer(32'h0A, 8, rd);
        xfer(32'h01, 8, rd);
        xfer(32'h02, 8, rd);
        cs_end();
        exp_tog = ~exp_tog;
        check("nb_tog", {31'd0, leds[2]}, {31'd0, exp_tog});
        check("nb_wrap", {31'd0, leds[3]}, 0);
        read_word(7'h06, rd);
        check("nb_mem6", rd, 32'h66);
        cs_begin();
        xfer(32'h0B, 8, rd);
        xfer(32'd0, 16, rd);
        check("nb_rd2", rd, 32'h0100);
        check("nb_oe_hold", {31'd0, spi.miso_oe}, 1);
        cs_end();
        write_word(7'h05, 8'hA5);
`endif

        // aborted write leaves memory alone
        cs_begin();
        xfer(32'h0A, 8, rd);
        xfer(32'hA, 4, rd);
        cs_end();
        check("ab_tog", {31'd0, leds[2]}, {31'd0, exp_tog});
        read_word(7'h05, rd);
        check("ab_mem5", rd, 32'hA5);

        // async reset during the second data bit
        cs_begin();
        xfer(32'h0A, 8, rd);
        xfer(32'h1, 1, rd);
        spi.mosi_pin = 1'b1;
        wait_clk(4);
        reset_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_oe", {31'd0, spi.miso_oe}, 0);
        check("rst_miso", {31'd0, spi.miso_pin}, 0);
        check("rst_leds", {28'd0, leds}, 0);
        wait_clk(1);
        reset_n = 1'b1;
        exp_tog = 1'b0;
        wait_clk(3);
        spi.cs_pin = 1'b1;
        wait_clk(16);
        read_word(7'h05, rd);
        check("rst_mem5", rd, 32'hA5);
        write_word(7'h05, 8'h5A);
        check("rst_tog", {31'd0, leds[2]}, {31'd0, exp_tog});
        read_word(7'h05, rd);
        check("rst_wr5", rd, 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
